// File: rtl/irq_timer_pkg.sv
// Shared register map and TCON bit positions for the irq_timer peripheral.
package irq_timer_pkg;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam logic [1:0] OFS_TH    = 2'd0;
  localparam logic [1:0] OFS_TL    = 2'd1;
  localparam logic [1:0] OFS_TCON  = 2'd2;
  localparam logic [1:0] OFS_PRESC = 2'd3;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;
endpackage

// File: rtl/irq_timer_prescaler.sv
// Prescale divider: one tick every presc+1 enabled cycles; restarts when disabled or reloaded.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] presc,
  output logic        tick
);
  logic [15:0] r_cnt;
  logic        w_wrap;

  assign w_wrap = (r_cnt == presc);
  assign tick   = en & ~load & w_wrap;

  always_ff @(posedge clk) begin
    if (reset || !en || load || w_wrap) r_cnt <= '0;
    else                                r_cnt <= r_cnt + 16'd1;
  end
endmodule

// File: rtl/irq_timer.sv
// Memory-mapped 32-bit reload timer with level overflow interrupt.
// Optional prescaler at offset 3 enabled by defining IRQ_TIMER_PRESCALE_EN.
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter logic [31:0] RESET_TH  = 32'h0000_0000,
  parameter logic [31:0] RESET_TL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] rdata,
  output logic        irq
);
  logic [31:0] r_th, r_tl;
  logic        r_en, r_ie, r_st;
  logic        w_sel, w_wr, w_tick, w_cnt, w_ovf;
  logic [1:0]  w_ofs;
  logic [31:0] w_rdata;
  logic        w_unused_lsb;

  assign w_sel        = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_ofs        = addr[3:2];
  assign w_wr         = wr & w_sel;
  assign w_unused_lsb = ^addr[1:0];

`ifdef IRQ_TIMER_PRESCALE_EN
  logic [15:0] r_presc;
  logic        w_presc_wr;

  assign w_presc_wr = w_wr && (w_ofs == OFS_PRESC);

  always_ff @(posedge clk) begin
    if (reset)           r_presc <= '0;
    else if (w_presc_wr) r_presc <= wdata[15:0];
  end

  timer_prescaler u_presc (
    .clk  (clk),
    .reset(reset),
    .en   (r_en),
    .load (w_presc_wr),
    .presc(r_presc),
    .tick (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  assign w_cnt = r_en & w_tick;
  assign w_ovf = w_cnt & (r_tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_th <= RESET_TH;
      r_tl <= RESET_TL;
      r_en <= 1'b0;
      r_ie <= 1'b0;
      r_st <= 1'b0;
    end else begin
      if (w_cnt) r_tl <= w_ovf ? r_th : r_tl + 32'd1;
      if (w_wr) begin
        case (w_ofs)
          OFS_TH:   r_th <= wdata;
          OFS_TL:   r_tl <= wdata;
          OFS_TCON: begin
            r_en <= wdata[TCON_EN];
            r_ie <= wdata[TCON_IE];
            if (!wdata[TCON_ST]) r_st <= 1'b0;
          end
          default: ;
        endcase
      end
      // Placed after the clear so an overflow in the acknowledge cycle is never lost.
      if (w_ovf) r_st <= 1'b1;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (rd && w_sel) begin
      case (w_ofs)
        OFS_TH:   w_rdata = r_th;
        OFS_TL:   w_rdata = r_tl;
        OFS_TCON: w_rdata = {29'd0, r_st, r_ie, r_en};
`ifdef IRQ_TIMER_PRESCALE_EN
        OFS_PRESC: w_rdata = {16'd0, r_presc};
`endif
        default:  w_rdata = '0;
      endcase
    end
  end

  assign rdata = w_rdata;
  assign irq   = r_ie & r_st;
endmodule
